// File: rtl/flit_sink_vc_checker.sv
// rtl/flit_sink_vc_checker.sv - per-VC flit ejection sink with LFSR-gated drain, credits and packet checks
// Optional latency statistics are compiled in with SINK_LATENCY_STATS_EN.
module flit_sink_vc_checker #(
  parameter int          num_vcs            = 4,
  parameter int          buffer_size        = 16,
  parameter int          flit_data_width    = 64,
  parameter int          consume_rate       = 8,
  parameter logic [15:0] lfsr_seed          = 16'hACE1,
  parameter int          max_payload_length = 4,
  parameter int          count_width        = 32,
  parameter int          timestamp_width    = 16,
  localparam int         vc_idx_width       = (num_vcs > 1) ? $clog2(num_vcs) : 1,
  localparam int         len_width          = $clog2(max_payload_length + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flit_valid_in,
  input  logic [vc_idx_width-1:0]    flit_vc_in,
  input  logic                       flit_head_in,
  input  logic                       flit_tail_in,
  input  logic [flit_data_width-1:0] flit_data_in,
`ifdef SINK_LATENCY_STATS_EN
  input  logic [timestamp_width-1:0] now_ts,
  output logic [count_width-1:0]     lat_sum,
  output logic [timestamp_width-1:0] lat_max,
`endif
  output logic [vc_idx_width:0]      flow_ctrl_out,
  output logic                       pkt_done,
  output logic [vc_idx_width-1:0]    pkt_vc,
  output logic [len_width-1:0]       pkt_len,
  output logic [count_width-1:0]     pkt_count,
  output logic [count_width-1:0]     flit_count,
  output logic                       error_ovf,
  output logic                       error_proto,
  output logic                       error_len,
  output logic                       error
);

  localparam int depth      = buffer_size / num_vcs;
  localparam int ptr_width  = (depth > 1) ? $clog2(depth) : 1;
  localparam int occ_width  = $clog2(depth + 1);
  localparam int lenw       = $clog2(max_payload_length + 2);

  if (depth < 2) begin : g_bad_depth
    $error("flit_sink_vc_checker: per-VC depth must be at least 2");
  end
  if (timestamp_width < 1 || timestamp_width > flit_data_width) begin : g_bad_ts
    $error("flit_sink_vc_checker: timestamp_width must fit inside the flit payload");
  end

  typedef enum logic {IDLE, IN_PKT} pkt_state_e;

  logic [15:0]             lfsr_q, lfsr_d;
  logic                    head_mem_q [num_vcs][depth];
  logic                    tail_mem_q [num_vcs][depth];
  logic [ptr_width-1:0]    wr_ptr_q [num_vcs];
  logic [ptr_width-1:0]    rd_ptr_q [num_vcs];
  logic [occ_width-1:0]    occ_q [num_vcs];
  logic [occ_width-1:0]    occ_d [num_vcs];
  pkt_state_e              state_q [num_vcs];
  pkt_state_e              state_d [num_vcs];
  logic [lenw-1:0]         len_q [num_vcs];
  logic [lenw-1:0]         len_d [num_vcs];
  logic [vc_idx_width-1:0] rr_ptr_q, rr_ptr_d, pop_vc, cand;
  logic                    consume, pop_valid, pop_head, pop_tail, push_ok;
  logic                    ovf_set, proto_set, len_set, done_d;
  logic [lenw-1:0]         next_len, done_len_d;
  logic [vc_idx_width:0]   flow_ctrl_q;
  logic                    pkt_done_q;
  logic [vc_idx_width-1:0] pkt_vc_q;
  logic [len_width-1:0]    pkt_len_q;
  logic [count_width-1:0]  pkt_count_q, flit_count_q;
  logic                    ovf_q, proto_q, len_err_q;

  function automatic logic [ptr_width-1:0] ptr_inc(input logic [ptr_width-1:0] p);
    return (int'(p) == depth - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    consume    = int'(lfsr_q[3:0]) < consume_rate;
    pop_valid  = 1'b0;
    pop_vc     = '0;
    cand       = '0;
    for (int k = 0; k < num_vcs; k++) begin
      cand = vc_idx_width'((int'(rr_ptr_q) + k) % num_vcs);
      if (consume && !pop_valid && occ_q[cand] != '0) begin
        pop_valid = 1'b1;
        pop_vc    = cand;
      end
    end
    pop_head = head_mem_q[pop_vc][rd_ptr_q[pop_vc]];
    pop_tail = tail_mem_q[pop_vc][rd_ptr_q[pop_vc]];
    rr_ptr_d = rr_ptr_q;
    if (pop_valid) rr_ptr_d = (int'(pop_vc) == num_vcs - 1) ? '0 : pop_vc + 1'b1;

    // A full VC still accepts when it is the one being drained this cycle.
    push_ok = flit_valid_in &&
              ((int'(occ_q[flit_vc_in]) < depth) || (pop_valid && pop_vc == flit_vc_in));
    ovf_set = flit_valid_in && !push_ok;

    for (int v = 0; v < num_vcs; v++) begin
      occ_d[v]   = occ_q[v];
      state_d[v] = state_q[v];
      len_d[v]   = len_q[v];
      if (push_ok && int'(flit_vc_in) == v) occ_d[v] = occ_d[v] + 1'b1;
      if (pop_valid && int'(pop_vc) == v)   occ_d[v] = occ_d[v] - 1'b1;
    end

    proto_set  = 1'b0;
    len_set    = 1'b0;
    done_d     = 1'b0;
    done_len_d = '0;
    next_len   = '0;
    if (pop_valid) begin
      if (pop_head) begin
        if (state_q[pop_vc] == IN_PKT) proto_set = 1'b1;
        if (pop_tail) begin
          done_d          = 1'b1;
          done_len_d      = lenw'(1);
          state_d[pop_vc] = IDLE;
        end else begin
          state_d[pop_vc] = IN_PKT;
          len_d[pop_vc]   = lenw'(1);
        end
      end else if (state_q[pop_vc] == IDLE) begin
        proto_set = 1'b1;
      end else begin
        next_len = (int'(len_q[pop_vc]) > max_payload_length) ? len_q[pop_vc]
                                                              : len_q[pop_vc] + 1'b1;
        if (int'(next_len) > max_payload_length) len_set = 1'b1;
        len_d[pop_vc] = next_len;
        if (pop_tail) begin
          done_d          = 1'b1;
          done_len_d      = next_len;
          state_d[pop_vc] = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q       <= (lfsr_seed == 16'h0) ? 16'h1 : lfsr_seed;
      rr_ptr_q     <= '0;
      flow_ctrl_q  <= '0;
      pkt_done_q   <= 1'b0;
      pkt_vc_q     <= '0;
      pkt_len_q    <= '0;
      pkt_count_q  <= '0;
      flit_count_q <= '0;
      ovf_q        <= 1'b0;
      proto_q      <= 1'b0;
      len_err_q    <= 1'b0;
      for (int v = 0; v < num_vcs; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        occ_q[v]    <= '0;
        state_q[v]  <= IDLE;
        len_q[v]    <= '0;
        for (int s = 0; s < depth; s++) begin
          head_mem_q[v][s] <= 1'b0;
          tail_mem_q[v][s] <= 1'b0;
        end
      end
    end else begin
      lfsr_q      <= lfsr_d;
      rr_ptr_q    <= rr_ptr_d;
      flow_ctrl_q <= pop_valid ? {1'b1, pop_vc} : '0;
      pkt_done_q  <= done_d;
      if (done_d) begin
        pkt_vc_q    <= pop_vc;
        pkt_len_q   <= len_width'(done_len_d);
        pkt_count_q <= pkt_count_q + 1'b1;
      end
      if (pop_valid) begin
        flit_count_q     <= flit_count_q + 1'b1;
        rd_ptr_q[pop_vc] <= ptr_inc(rd_ptr_q[pop_vc]);
      end
      if (push_ok) begin
        head_mem_q[flit_vc_in][wr_ptr_q[flit_vc_in]] <= flit_head_in;
        tail_mem_q[flit_vc_in][wr_ptr_q[flit_vc_in]] <= flit_tail_in;
        wr_ptr_q[flit_vc_in] <= ptr_inc(wr_ptr_q[flit_vc_in]);
      end
      ovf_q     <= ovf_q | ovf_set;
      proto_q   <= proto_q | proto_set;
      len_err_q <= len_err_q | len_set;
      for (int v = 0; v < num_vcs; v++) begin
        occ_q[v]   <= occ_d[v];
        state_q[v] <= state_d[v];
        len_q[v]   <= len_d[v];
      end
    end
  end

`ifdef SINK_LATENCY_STATS_EN
  logic [timestamp_width-1:0] ts_mem_q [num_vcs][depth];
  logic [timestamp_width-1:0] head_ts_q [num_vcs];
  logic [timestamp_width-1:0] pop_ts, lat_val;
  logic [count_width-1:0]     lat_sum_q;
  logic [timestamp_width-1:0] lat_max_q;

  // Single-flit packets take their injection time straight from the flit being popped.
  always_comb begin
    pop_ts  = ts_mem_q[pop_vc][rd_ptr_q[pop_vc]];
    lat_val = now_ts - (pop_head ? pop_ts : head_ts_q[pop_vc]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_sum_q <= '0;
      lat_max_q <= '0;
      for (int v = 0; v < num_vcs; v++) begin
        head_ts_q[v] <= '0;
        for (int s = 0; s < depth; s++) ts_mem_q[v][s] <= '0;
      end
    end else begin
      if (push_ok)
        ts_mem_q[flit_vc_in][wr_ptr_q[flit_vc_in]] <=
          flit_data_in[flit_data_width-timestamp_width +: timestamp_width];
      if (pop_valid && pop_head) head_ts_q[pop_vc] <= pop_ts;
      if (done_d) begin
        lat_sum_q <= lat_sum_q + count_width'(lat_val);
        if (lat_val > lat_max_q) lat_max_q <= lat_val;
      end
    end
  end

  assign lat_sum = lat_sum_q;
  assign lat_max = lat_max_q;
`endif

  assign flow_ctrl_out = flow_ctrl_q;
  assign pkt_done      = pkt_done_q;
  assign pkt_vc        = pkt_vc_q;
  assign pkt_len       = pkt_len_q;
  assign pkt_count     = pkt_count_q;
  assign flit_count    = flit_count_q;
  assign error_ovf     = ovf_q;
  assign error_proto   = proto_q;
  assign error_len     = len_err_q;
  assign error         = ovf_q | proto_q | len_err_q;

endmodule

// File: tb/tb_flit_sink_vc_checker.sv
// tb/tb_flit_sink_vc_checker.sv - directed self-checking bench for flit_sink_vc_checker
// Two instances share stimulus: one drains every cycle, one never drains.
module tb_flit_sink_vc_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        flit_valid_in, flit_head_in, flit_tail_in;
  logic [1:0]  flit_vc_in;
  logic [63:0] flit_data_in;

  logic [2:0]  f_flow, s_flow;
  logic        f_done, s_done;
  logic [1:0]  f_vc, s_vc;
  logic [2:0]  f_len, s_len;
  logic [31:0] f_pkts, s_pkts, f_flits, s_flits;
  logic        f_ovf, s_ovf, f_proto, s_proto, f_lerr, s_lerr, f_err, s_err;
`ifdef SINK_LATENCY_STATS_EN
  logic [15:0] now_ts;
  logic [31:0] f_lat_sum, s_lat_sum;
  logic [15:0] f_lat_max, s_lat_max;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flit_sink_vc_checker #(.consume_rate(16)) u_fast (
    .clk(clk), .reset(reset), .flit_valid_in(flit_valid_in), .flit_vc_in(flit_vc_in),
    .flit_head_in(flit_head_in), .flit_tail_in(flit_tail_in), .flit_data_in(flit_data_in),
`ifdef SINK_LATENCY_STATS_EN
    .now_ts(now_ts), .lat_sum(f_lat_sum), .lat_max(f_lat_max),
`endif
    .flow_ctrl_out(f_flow), .pkt_done(f_done), .pkt_vc(f_vc), .pkt_len(f_len),
    .pkt_count(f_pkts), .flit_count(f_flits), .error_ovf(f_ovf),
    .error_proto(f_proto), .error_len(f_lerr), .error(f_err)
  );

  flit_sink_vc_checker #(.consume_rate(0)) u_stall (
    .clk(clk), .reset(reset), .flit_valid_in(flit_valid_in), .flit_vc_in(flit_vc_in),
    .flit_head_in(flit_head_in), .flit_tail_in(flit_tail_in), .flit_data_in(flit_data_in),
`ifdef SINK_LATENCY_STATS_EN
    .now_ts(now_ts), .lat_sum(s_lat_sum), .lat_max(s_lat_max),
`endif
    .flow_ctrl_out(s_flow), .pkt_done(s_done), .pkt_vc(s_vc), .pkt_len(s_len),
    .pkt_count(s_pkts), .flit_count(s_flits), .error_ovf(s_ovf),
    .error_proto(s_proto), .error_len(s_lerr), .error(s_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int vc, input bit h, input bit t);
    flit_valid_in = 1'b1;
    flit_vc_in    = 2'(vc);
    flit_head_in  = h;
    flit_tail_in  = t;
  endtask

  task automatic idle();
    flit_valid_in = 1'b0;
    flit_head_in  = 1'b0;
    flit_tail_in  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (!f_done && n < bound) begin
      tick();
      n++;
    end
    check(tag, 32'(f_done), 1);
  endtask

  initial begin
    flit_vc_in   = '0;
    flit_data_in = '0;
`ifdef SINK_LATENCY_STATS_EN
    now_ts = '0;
`endif
    do_reset();
    check("rst_flow", 32'(f_flow), 0);
    check("rst_done", 32'(f_done), 0);
    check("rst_pkts", f_pkts, 0);
    check("rst_flits", f_flits, 0);
    check("rst_err", 32'(f_err), 0);
    check("rst_stall_err", 32'(s_err), 0);

    // 3-flit packet on VC2 pushed in cycles 1-3
    push(2, 1, 0); tick();
    check("t1_c2_flow", 32'(f_flow), 0);
    push(2, 0, 0); tick();
    check("t1_c3_flow", 32'(f_flow), 6);
    push(2, 0, 1); tick();
    check("t1_c4_flow", 32'(f_flow), 6);
    check("t1_c4_done", 32'(f_done), 0);
    idle(); tick();
    check("t1_c5_flow", 32'(f_flow), 6);
    check("t1_c5_done", 32'(f_done), 1);
    check("t1_c5_vc", 32'(f_vc), 2);
    check("t1_c5_len", 32'(f_len), 3);
    check("t1_c5_pkts", f_pkts, 1);
    tick();
    check("t1_c6_flow", 32'(f_flow), 0);
    check("t1_c6_done", 32'(f_done), 0);
    check("t1_flits", f_flits, 3);
    check("t1_stall_flow", 32'(s_flow), 0);

    // two single-flit packets per VC, credits in VC order 0..3 twice
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(i % 4, 1, 1); tick();
      if (i > 0) check("t2_flow", 32'(f_flow), 32'(4 + (i - 1) % 4));
    end
    idle(); tick();
    check("t2_flow_last", 32'(f_flow), 7);
    tick(); tick();
    check("t2_pkts", f_pkts, 8);
    check("t2_flits", f_flits, 8);
    check("t2_err", 32'(f_err), 0);

    // overflow: 5 pushes into VC1 with no draining
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(1, 1, 1); tick();
    end
    check("t3_ovf_at_depth", 32'(s_ovf), 0);
    push(1, 1, 1); tick();
    idle();
    check("t3_ovf", 32'(s_ovf), 1);
    check("t3_err", 32'(s_err), 1);
    check("t3_flow", 32'(s_flow), 0);
    check("t3_flits", s_flits, 0);
    check("t3_fast_ovf", 32'(f_ovf), 0);

    // body to IDLE VC0, then head,head,tail on VC1
    do_reset();
    push(0, 0, 0); tick();
    check("t4_proto_pre", 32'(f_proto), 0);
    push(1, 1, 0); tick();
    check("t4_proto_body", 32'(f_proto), 1);
    push(1, 1, 0); tick();
    push(1, 0, 1); tick();
    idle();
    wait_done("t4_done", 8);
    check("t4_len", 32'(f_len), 2);
    check("t4_vc", 32'(f_vc), 1);
    check("t4_pkts", f_pkts, 1);
    tick();
    check("t4_flits", f_flits, 4);
    check("t4_lerr", 32'(f_lerr), 0);
    check("t4_ovf", 32'(f_ovf), 0);

    // 6-flit packet on VC3 exceeds the 4-flit limit
    do_reset();
    push(3, 1, 0); tick();
    for (int i = 0; i < 4; i++) begin
      push(3, 0, 0); tick();
    end
    push(3, 0, 1); tick();
    idle();
    wait_done("t5_done", 8);
    check("t5_len", 32'(f_len), 5);
    check("t5_vc", 32'(f_vc), 3);
    check("t5_lerr", 32'(f_lerr), 1);
    check("t5_err", 32'(f_err), 1);
    check("t5_proto", 32'(f_proto), 0);
    check("t5_pkts", f_pkts, 1);

`ifdef SINK_LATENCY_STATS_EN
    // latencies 10 and 25, the second across timestamp wrap
    do_reset();
    now_ts = 16'd110;
    flit_data_in = {16'd100, 48'd0};
    push(0, 1, 1); tick();
    idle(); tick(); tick();
    check("t6_sum1", f_lat_sum, 10);
    check("t6_max1", 32'(f_lat_max), 10);
    now_ts = 16'd9;
    flit_data_in = {16'd65520, 48'd0};
    push(1, 1, 1); tick();
    idle(); tick(); tick();
    check("t6_sum2", f_lat_sum, 35);
    check("t6_max2", 32'(f_lat_max), 25);
    flit_data_in = '0;
    now_ts = '0;
`endif

    // asynchronous reset in the middle of a VC2 packet
    do_reset();
    push(2, 1, 0); tick();
    push(2, 0, 0); tick();
    idle();
    check("t7_flow_pre", 32'(f_flow), 6);
    #2 reset = 1'b1;
    #1;
    check("t7_flow_async", 32'(f_flow), 0);
    check("t7_flits_async", f_flits, 0);
    check("t7_err_async", 32'(f_err), 0);
    tick();
    reset = 1'b0;
    push(2, 1, 0); tick();
    push(2, 0, 1); tick();
    idle();
    wait_done("t7_done", 8);
    check("t7_len", 32'(f_len), 2);
    check("t7_pkts", f_pkts, 1);
    check("t7_err", 32'(f_err), 0);
    tick();
    check("t7_flits", f_flits, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
